// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: NUM_CH outputs share one prescaler and period counter; duty/period writes
// are shadowed and reloaded at period boundaries. Define PWM_CENTER_ALIGN_EN for up/down counting.
module pwm_multi_channel #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 8,
  parameter int unsigned ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  output logic [NUM_CH-1:0]  pwm_out,
  output logic               period_end,
  output logic [WIDTH-1:0]   cnt_out
);

  localparam logic [ADDR_W-1:0] PeriodAddr = ADDR_W'(NUM_CH);

  logic [PRESC_W-1:0]            psc_q, psc_d;
  logic [WIDTH-1:0]              cnt_q, cnt_d;
  logic [WIDTH-1:0]              period_sh_q, period_sh_d, period_act_q;
  logic [NUM_CH-1:0][WIDTH-1:0]  duty_sh_q, duty_sh_d, duty_act_q;
  logic [NUM_CH-1:0]             pwm_q, pwm_d;
  logic                          period_end_q;
  logic                          tick, boundary;

`ifdef PWM_CENTER_ALIGN_EN
  typedef enum logic {DirUp, DirDown} dir_e;
  dir_e dir_q, dir_d;
`endif

  // Shadow register writes; addresses above NUM_CH are dropped.
  always_comb begin
    duty_sh_d   = duty_sh_q;
    period_sh_d = period_sh_q;
    if (wr_en) begin
      if (wr_addr == PeriodAddr) begin
        period_sh_d = wr_data;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_addr == ADDR_W'(i)) duty_sh_d[i] = wr_data;
        end
      end
    end
  end

  always_comb begin
    psc_d    = psc_q;
    cnt_d    = cnt_q;
    tick     = 1'b0;
    boundary = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d    = dir_q;
`endif
    if (!en) begin
      psc_d = '0;
      cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d = DirUp;
`endif
    end else begin
      if (psc_q == prescale) begin
        tick  = 1'b1;
        psc_d = '0;
      end else begin
        psc_d = psc_q + 1'b1;
      end
      if (tick) begin
`ifdef PWM_CENTER_ALIGN_EN
        if (period_act_q == '0) begin
          boundary = 1'b1;
        end else if (dir_q == DirDown || cnt_q >= period_act_q) begin
          // Descending: the step from 1 to 0 closes the period.
          if (cnt_q <= WIDTH'(1)) begin
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
            dir_d = DirDown;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (boundary) dir_d = DirUp;
`else
        if (cnt_q >= period_act_q) begin
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (boundary) cnt_d = '0;
      end
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = en && (cnt_q < duty_act_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q        <= '0;
      cnt_q        <= '0;
      pwm_q        <= '0;
      period_end_q <= 1'b0;
      duty_sh_q    <= '0;
      duty_act_q   <= '0;
      period_sh_q  <= '1;
      period_act_q <= '1;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q        <= DirUp;
`endif
    end else begin
      psc_q        <= psc_d;
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
      period_end_q <= boundary;
      duty_sh_q    <= duty_sh_d;
      period_sh_q  <= period_sh_d;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q        <= dir_d;
`endif
      // Reload takes the pre-write shadow when a write coincides with the boundary.
      if (boundary) begin
        duty_act_q   <= duty_sh_q;
        period_act_q <= period_sh_q;
      end
    end
  end

  assign pwm_out    = pwm_q;
  assign period_end = period_end_q;
  assign cnt_out    = cnt_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: per-period high-time windows are scoreboarded.
// Build with PWM_CENTER_ALIGN_EN to exercise the up/down counter instead of edge-aligned tests.
module tb_pwm_multi_channel;

  localparam int NUM_CH = 4, WIDTH = 8, PRESC_W = 8, ADDR_W = 3;

  logic               clk = 1'b0;
  logic               rst, en, wr_en;
  logic [PRESC_W-1:0] prescale;
  logic [ADDR_W-1:0]  wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [NUM_CH-1:0]  pwm_out;
  logic               period_end;
  logic [WIDTH-1:0]   cnt_out;

  pwm_multi_channel #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH),
    .PRESC_W(PRESC_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .prescale  (prescale),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pwm_out   (pwm_out),
    .period_end(period_end),
    .cnt_out   (cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned len;
    int unsigned h0, h1, h2, h3;
  } win_t;

  win_t        exp_q[$];
  win_t        obs_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          drop_next = 1'b0;
  bit          acc_clear = 1'b0;
  int unsigned acc_len;
  int unsigned acc_hi[NUM_CH];

  // Window = samples after one period_end up to and including the next one.
  always @(negedge clk) begin
    if (acc_clear || rst) begin
      acc_len = 0;
      for (int i = 0; i < NUM_CH; i++) acc_hi[i] = 0;
      acc_clear = 1'b0;
    end
    if (!rst) begin
      acc_len++;
      for (int i = 0; i < NUM_CH; i++) acc_hi[i] += 32'(pwm_out[i]);
      if (period_end) begin
        if (drop_next) begin
          drop_next = 1'b0;
        end else begin
          obs_q.push_back('{len: acc_len, h0: acc_hi[0], h1: acc_hi[1], h2: acc_hi[2],
                            h3: acc_hi[3]});
        end
        acc_len = 0;
        for (int i = 0; i < NUM_CH; i++) acc_hi[i] = 0;
      end
    end
  end

  function automatic string fmt(input win_t w);
    return $sformatf("len=%0d hi=%0d/%0d/%0d/%0d", w.len, w.h0, w.h1, w.h2, w.h3);
  endfunction

  task automatic advance();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    advance();
    wr_en   = 1'b0;
  endtask

  task automatic push_exp(input int unsigned len, input int unsigned h0, input int unsigned h1,
                          input int unsigned h2, input int unsigned h3);
    exp_q.push_back('{len: len, h0: h0, h1: h1, h2: h2, h3: h3});
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int k = 0; k < budget && obs_q.size() < n; k++) advance();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; prescale = '0; wr_addr = '0; wr_data = '0;
    advance();
    advance();
    checks++;
    if (pwm_out !== 4'b0000) begin
      errors++; $display("FAIL reset_pwm: got %b expected 0000", pwm_out);
    end
    checks++;
    if (cnt_out !== 8'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_out);
    end
    checks++;
    if (period_end !== 1'b0) begin
      errors++; $display("FAIL reset_period_end: got %b expected 0", period_end);
    end
  endtask

  task automatic test_defaults();
    win_t w_o, w_e;
    rst = 1'b0; en = 1'b1; prescale = '0;
    drop_next = 1'b1; obs_q.delete(); exp_q.delete();
    repeat (2) push_exp(256, 0, 0, 0, 0);
    wait_obs(2, 1000);
    for (int k = 0; k < 2; k++) begin
      checks++;
      w_e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL defaults_win%0d: got no window expected %s", k, fmt(w_e));
      end else begin
        w_o = obs_q.pop_front();
        if (w_o !== w_e) begin
          errors++; $display("FAIL defaults_win%0d: got %s expected %s", k, fmt(w_o), fmt(w_e));
        end
      end
    end
    checks++;
    if (period_end !== 1'b1 || cnt_out !== 8'd0) begin
      errors++;
      $display("FAIL defaults_wrap: got pe=%b cnt=%0d expected pe=1 cnt=0", period_end, cnt_out);
    end
  endtask

  task automatic test_basic();
    win_t w_o, w_e;
    drop_next = 1'b1; obs_q.delete(); exp_q.delete();
    wr(3'd4, 8'd9);
    wr(3'd0, 8'd3);
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd10);
    wr(3'd3, 8'd5);
    wr(3'd5, 8'd1);
    wr(3'd6, 8'd1);
    wr(3'd7, 8'd1);
    repeat (3) push_exp(10, 3, 0, 10, 5);
    wait_obs(3, 700);
    for (int k = 0; k < 3; k++) begin
      checks++;
      w_e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL basic_win%0d: got no window expected %s", k, fmt(w_e));
      end else begin
        w_o = obs_q.pop_front();
        if (w_o !== w_e) begin
          errors++; $display("FAIL basic_win%0d: got %s expected %s", k, fmt(w_o), fmt(w_e));
        end
      end
    end
  endtask

  task automatic test_shadow();
    win_t w_o, w_e;
    obs_q.delete(); exp_q.delete();
    push_exp(10, 3, 0, 10, 5);
    push_exp(10, 7, 0, 10, 5);
    repeat (4) advance();
    wr(3'd0, 8'd7);
    wait_obs(2, 100);
    obs_q.delete();
    push_exp(10, 7, 0, 10, 5);
    push_exp(10, 7, 0, 10, 5);
    push_exp(10, 1, 0, 10, 5);
    repeat (9) advance();
    checks++;
    if (cnt_out !== 8'd9) begin
      errors++; $display("FAIL shadow_last_cnt: got %0d expected 9", cnt_out);
    end
    wr(3'd0, 8'd1);
    wait_obs(3, 100);
    for (int k = 0; k < 5; k++) begin
      checks++;
      w_e = exp_q.pop_front();
      if (k < 2) continue;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL shadow_win%0d: got no window expected %s", k, fmt(w_e));
      end else begin
        w_o = obs_q.pop_front();
        if (w_o !== w_e) begin
          errors++; $display("FAIL shadow_win%0d: got %s expected %s", k, fmt(w_o), fmt(w_e));
        end
      end
    end
  endtask

  task automatic test_prescaler();
    win_t w_o, w_e;
    prescale = 8'd3;
    wr(3'd4, 8'd4);
    wr(3'd0, 8'd2);
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd5);
    wr(3'd3, 8'd4);
    drop_next = 1'b1; obs_q.delete(); exp_q.delete();
    repeat (2) push_exp(20, 8, 0, 20, 16);
    wait_obs(2, 200);
    for (int k = 0; k < 2; k++) begin
      checks++;
      w_e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL presc_win%0d: got no window expected %s", k, fmt(w_e));
      end else begin
        w_o = obs_q.pop_front();
        if (w_o !== w_e) begin
          errors++; $display("FAIL presc_win%0d: got %s expected %s", k, fmt(w_o), fmt(w_e));
        end
      end
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (cnt_out !== 8'(k / 4)) begin
        errors++; $display("FAIL presc_cnt%0d: got %0d expected %0d", k, cnt_out, k / 4);
      end
      advance();
    end
  endtask

  task automatic test_enable();
    win_t w_o, w_e;
    en = 1'b0;
    advance();
    wr(3'd4, 8'd9);
    wr(3'd0, 8'd3);
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd10);
    wr(3'd3, 8'd5);
    prescale = '0;
    en = 1'b1; acc_clear = 1'b1; obs_q.delete(); exp_q.delete();
    // First period after enable still runs on the old active values.
    push_exp(5, 2, 0, 5, 4);
    push_exp(10, 3, 0, 10, 5);
    wait_obs(2, 100);
    for (int k = 0; k < 2; k++) begin
      checks++;
      w_e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL en_reload_win%0d: got no window expected %s", k, fmt(w_e));
      end else begin
        w_o = obs_q.pop_front();
        if (w_o !== w_e) begin
          errors++;
          $display("FAIL en_reload_win%0d: got %s expected %s", k, fmt(w_o), fmt(w_e));
        end
      end
    end
    repeat (5) advance();
    checks++;
    if (cnt_out !== 8'd5) begin
      errors++; $display("FAIL en_mid_cnt: got %0d expected 5", cnt_out);
    end
    en = 1'b0;
    advance();
    checks++;
    if (cnt_out !== 8'd0 || pwm_out !== 4'b0000 || period_end !== 1'b0) begin
      errors++;
      $display("FAIL en_off: got cnt=%0d pwm=%b pe=%b expected cnt=0 pwm=0000 pe=0",
               cnt_out, pwm_out, period_end);
    end
    wr(3'd0, 8'd7);
    repeat (3) advance();
    checks++;
    if (cnt_out !== 8'd0 || pwm_out !== 4'b0000) begin
      errors++; $display("FAIL en_hold: got cnt=%0d pwm=%b expected cnt=0 pwm=0000", cnt_out,
                         pwm_out);
    end
    en = 1'b1; acc_clear = 1'b1; obs_q.delete(); exp_q.delete();
    push_exp(10, 3, 0, 10, 5);
    push_exp(10, 7, 0, 10, 5);
    advance();
    checks++;
    if (cnt_out !== 8'd1 || pwm_out !== 4'b1101) begin
      errors++; $display("FAIL en_resume: got cnt=%0d pwm=%b expected cnt=1 pwm=1101", cnt_out,
                         pwm_out);
    end
    wait_obs(2, 100);
    for (int k = 0; k < 2; k++) begin
      checks++;
      w_e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL en_resume_win%0d: got no window expected %s", k, fmt(w_e));
      end else begin
        w_o = obs_q.pop_front();
        if (w_o !== w_e) begin
          errors++;
          $display("FAIL en_resume_win%0d: got %s expected %s", k, fmt(w_o), fmt(w_e));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    win_t w_o, w_e;
    int   pe_seen, hi_seen;
    repeat (5) advance();
    checks++;
    if (cnt_out !== 8'd5) begin
      errors++; $display("FAIL rst_mid_cnt: got %0d expected 5", cnt_out);
    end
    rst = 1'b1;
    advance();
    checks++;
    if (cnt_out !== 8'd0 || pwm_out !== 4'b0000 || period_end !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got cnt=%0d pwm=%b pe=%b expected cnt=0 pwm=0000 pe=0",
               cnt_out, pwm_out, period_end);
    end
    rst = 1'b0;
    drop_next = 1'b1; obs_q.delete(); exp_q.delete();
    push_exp(256, 0, 0, 0, 0);
    pe_seen = 0;
    hi_seen = 0;
    for (int k = 0; k < 12; k++) begin
      advance();
      pe_seen += int'(period_end);
      hi_seen += int'(pwm_out != 4'b0000);
    end
    checks++;
    if (cnt_out !== 8'd12 || pe_seen != 0 || hi_seen != 0) begin
      errors++;
      $display("FAIL rst_defaults: got cnt=%0d pe_pulses=%0d pwm_high=%0d expected 12/0/0",
               cnt_out, pe_seen, hi_seen);
    end
    wait_obs(1, 700);
    checks++;
    w_e = exp_q.pop_front();
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL rst_win: got no window expected %s", fmt(w_e));
    end else begin
      w_o = obs_q.pop_front();
      if (w_o !== w_e) begin
        errors++; $display("FAIL rst_win: got %s expected %s", fmt(w_o), fmt(w_e));
      end
    end
  endtask

  task automatic test_center();
    win_t w_o, w_e;
    int   seq[8];
    seq = '{0, 1, 2, 3, 4, 3, 2, 1};
    rst = 1'b0; en = 1'b1; prescale = '0;
    wr(3'd4, 8'd4);
    wr(3'd0, 8'd2);
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd5);
    wr(3'd3, 8'd4);
    drop_next = 1'b1; obs_q.delete(); exp_q.delete();
    repeat (2) push_exp(8, 3, 0, 8, 7);
    wait_obs(2, 1500);
    for (int k = 0; k < 2; k++) begin
      checks++;
      w_e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL center_win%0d: got no window expected %s", k, fmt(w_e));
      end else begin
        w_o = obs_q.pop_front();
        if (w_o !== w_e) begin
          errors++; $display("FAIL center_win%0d: got %s expected %s", k, fmt(w_o), fmt(w_e));
        end
      end
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cnt_out !== 8'(seq[k % 8]) || period_end !== (k % 8 == 0)) begin
        errors++;
        $display("FAIL center_seq%0d: got cnt=%0d pe=%b expected cnt=%0d pe=%b", k, cnt_out,
                 period_end, seq[k % 8], k % 8 == 0);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
`ifdef PWM_CENTER_ALIGN_EN
    test_center();
`else
    test_defaults();
    test_basic();
    test_shadow();
    test_prescaler();
    test_enable();
    test_reset_mid();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
